traffic_safety_monitor: RTL
===========================

// Module: traffic_safety_monitor
// PURPOSE
//  Downstream safety stage between traffic_control and the lamp drivers.
//  Samples the four 3-bit light buses and checks each one for illegal codes, conflicting right-of-way,
//  illegal sequences and dwell-time violations.
//  Passes legal codes to the lamp outputs with 1-cycle latency. On any violation it latches a fault and
//  forces all lamps red until an operator clear.
// PARAMETERS
//  CW         8   dwell counter width; counters saturate at 2**CW-1
//  YEL_MIN    2   min yellow dwell, in cycles
//  YEL_MAX    8   max yellow dwell, in cycles
//  GRN_MAX    16  max green dwell, in cycles
//  ARM_CYCLES 2   observe-only cycles after reset and after recovery
//  HOLD_CYCLES 8  forced all-red cycles after fault_clr
// PORTS
//  clk        in  1  system clock, rising edge
//  rst_a      in  1  asynchronous, active-low reset
//  n_light    in  3  north code from traffic_control (same for s_/e_/w_light)
//  s_light    in  3  south code
//  e_light    in  3  east code
//  w_light    in  3  west code
//  fault_clr  in  1  operator clear; sampled only in FAULT
//  n_lamp     out 3  registered lamp drive (same for s_/e_/w_lamp)
//  s_lamp     out 3  registered lamp drive, south
//  e_lamp     out 3  registered lamp drive, east
//  w_lamp     out 3  registered lamp drive, west
//  fault      out 1  1 while in FAULT
//  safe_mode  out 1  1 in FAULT or HOLD (lamps forced red)
//  fault_code out 3  first-fault code; sticky until leaving HOLD
//  fault_dir  out 2  direction of first fault: N=0, S=1, E=2, W=3
//  fault_cnt  out 8  number of faults since reset; saturates at 255
// BEHAVIOUR
//  Codes: 000 RED, 001 GREEN, 010 YELLOW; every other code is illegal. Forced red drives 000.
//  Reset: state=ARM, all lamps 000, fault=0, safe_mode=0, fault_code=0, fault_dir=0, fault_cnt=0.
//   Reset asserted mid-operation aborts any state immediately.
//  Per direction:
//   - prev code register; dwell counter reloads to 1 when the code changes, else increments (saturating).
//   - Legal transitions: R->R, R->G, G->G, G->Y, Y->Y, Y->R. All others are illegal transitions.
//  FSM:
//   ARM     Lamps 000. prev/dwell track the inputs; no checks run.
//           After ARM_CYCLES cycles -> MONITOR.
//   MONITOR Lamps <= inputs (1-cycle latency). A violation detected on the sampled inputs causes the
//           same edge to load lamps 000, enter FAULT, latch code/dir and increment fault_cnt.
//           A violating code therefore never reaches the lamps.
//   FAULT   Lamps 000, fault=1. Inputs ignored.
//           fault_clr=1 -> HOLD; the counter restarts.
//   HOLD    Lamps 000, fault=0. After HOLD_CYCLES cycles -> ARM.
//           fault_code and fault_dir clear on HOLD exit.
//  Fault codes (a lower code wins when several occur in one cycle):
//   1  illegal code
//   2  conflict: more than one direction non-RED
//   3  illegal transition
//   4  yellow ended with dwell < YEL_MIN
//   5  yellow dwell reached YEL_MAX+1
//   6  green dwell reached GRN_MAX+1
//   Ties in direction resolve to the lowest index (N first).
//  Dwell checks compare the counter value before reload. Saturation never wraps.
//  fault_clr outside FAULT is ignored. A fault_clr held high is consumed once.
// STRUCTURE
//  traffic_defs.vh (shared include): light codes, fault codes, FSM state encodings, direction indices.
//  Sub-module light_dir_checker, instantiated 4x: prev register, dwell counter, transition and timing
//   checks. Outputs a per-direction violation vector {illegal, trans, yshort, ylong, glong}.
//  Top level: conflict detection, priority encoding, FSM, lamp and status registers.
// TESTING
//  1 Release reset; drive N G8/Y4/R, then S, E, W in turn
//    -> lamps equal inputs delayed 1 cycle after ARM; fault=0; fault_cnt=0.
//  2 In MONITOR drive N=001 and E=001 in the same cycle
//    -> next edge: all lamps 000, fault=1, fault_code=2, fault_dir=0, fault_cnt=1.
//  3 N goes 001->000 directly -> fault_code=3, fault_dir=0. N goes 000->010 -> fault_code=3.
//  4 W yellow held 1 cycle, then red -> code 4, dir 3.
//    S green held 17 cycles -> code 6 on cycle 17.
//    E yellow held 9 cycles -> code 5.
//    Drive 011 on S together with a conflict -> code 1 wins.
//  5 In FAULT pulse fault_clr -> 8 cycles safe_mode=1 with lamps 000, then 2 ARM cycles, then pass-through;
//    fault_code returns to 0. fault_clr pulsed in MONITOR has no effect.
//  6 Assert rst_a low mid-FAULT and mid-HOLD -> all outputs at reset values asynchronously.
//    Inject 256 faults -> fault_cnt holds at 255.

Source files
------------

// File: rtl/traffic_safety_monitor_pkg.sv
// Shared constants for the traffic safety monitor: light codes, fault codes,
// FSM state encodings, direction indices and small decode helpers.
package traffic_safety_monitor_pkg;

  localparam int NUM_DIR = 4;
  localparam int LW      = 3;

  localparam logic [LW-1:0] LIGHT_RED    = 3'b000;
  localparam logic [LW-1:0] LIGHT_GREEN  = 3'b001;
  localparam logic [LW-1:0] LIGHT_YELLOW = 3'b010;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_TRANS    = 3'd3;
  localparam logic [2:0] FC_YSHORT   = 3'd4;
  localparam logic [2:0] FC_YLONG    = 3'd5;
  localparam logic [2:0] FC_GLONG    = 3'd6;

  localparam logic [1:0] ST_ARM     = 2'd0;
  localparam logic [1:0] ST_MONITOR = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Per-direction violation flags, ordered by fault-code priority.
  typedef struct packed {
    logic illegal;
    logic trans;
    logic yshort;
    logic ylong;
    logic glong;
  } dir_viol_t;

  function automatic logic is_legal(input logic [LW-1:0] c);
    return (c == LIGHT_RED) || (c == LIGHT_GREEN) || (c == LIGHT_YELLOW);
  endfunction

  // Allowed: R->R, R->G, G->G, G->Y, Y->Y, Y->R.
  function automatic logic legal_trans(input logic [LW-1:0] p, input logic [LW-1:0] c);
    logic ok;
    ok = 1'b0;
    case (p)
      LIGHT_RED:    ok = (c == LIGHT_RED)    || (c == LIGHT_GREEN);
      LIGHT_GREEN:  ok = (c == LIGHT_GREEN)  || (c == LIGHT_YELLOW);
      LIGHT_YELLOW: ok = (c == LIGHT_YELLOW) || (c == LIGHT_RED);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Lowest set index wins (N before S before E before W).
  function automatic logic [1:0] first_dir(input logic [NUM_DIR-1:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/traffic_safety_monitor_light_dir_checker.sv
// One direction's history (previous code, dwell counter) and the checks that
// depend on it. History always tracks the input; the top decides when the
// violation flags matter.
module light_dir_checker
  import traffic_safety_monitor_pkg::*;
#(
  parameter int CW      = 8,
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 8,
  parameter int GRN_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_a,
  input  logic [LW-1:0] cur,
  output dir_viol_t     viol
);

  localparam logic [CW-1:0] DWELL_SAT = '1;

  logic [LW-1:0] prev_q, prev_d;
  logic [CW-1:0] dwell_q, dwell_d;

  // Reload dwell on a code change, otherwise count up and stick at saturation.
  always_comb begin
    prev_d = cur;
    if (cur != prev_q)            dwell_d = CW'(1);
    else if (dwell_q == DWELL_SAT) dwell_d = dwell_q;
    else                           dwell_d = dwell_q + CW'(1);
  end

  // Checks look at the counter before it reloads.
  always_comb begin
    viol         = '0;
    viol.illegal = !is_legal(cur);
    viol.trans   = is_legal(cur) && !legal_trans(prev_q, cur);
    viol.yshort  = (prev_q == LIGHT_YELLOW) && (cur != LIGHT_YELLOW) && (dwell_q < CW'(YEL_MIN));
    viol.ylong   = (prev_q == LIGHT_YELLOW) && (cur == LIGHT_YELLOW) && (dwell_q >= CW'(YEL_MAX));
    viol.glong   = (prev_q == LIGHT_GREEN)  && (cur == LIGHT_GREEN)  && (dwell_q >= CW'(GRN_MAX));
  end

  // History registers.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      prev_q  <= LIGHT_RED;
      dwell_q <= '0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety stage between traffic_control and the lamp drivers: per-direction
// checkers, conflict detection, fault priority encoding, FSM and lamp/status
// registers. Legal codes reach the lamps one cycle late; any violation forces
// all-red until an operator clear and a hold period.
module traffic_safety_monitor
  import traffic_safety_monitor_pkg::*;
#(
  parameter int CW          = 8,
  parameter int YEL_MIN     = 2,
  parameter int YEL_MAX     = 8,
  parameter int GRN_MAX     = 16,
  parameter int ARM_CYCLES  = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_light,
  input  logic [2:0] s_light,
  input  logic [2:0] e_light,
  input  logic [2:0] w_light,
  input  logic       fault_clr,
  output logic [2:0] n_lamp,
  output logic [2:0] s_lamp,
  output logic [2:0] e_lamp,
  output logic [2:0] w_lamp,
  output logic       fault,
  output logic       safe_mode,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic [7:0] fault_cnt
);

  logic [NUM_DIR-1:0][LW-1:0] light;
  dir_viol_t [NUM_DIR-1:0]    viol;

  assign light = {w_light, e_light, s_light, n_light};

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_dir
    light_dir_checker #(
      .CW(CW), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GRN_MAX(GRN_MAX)
    ) u_chk (
      .clk  (clk),
      .rst_a(rst_a),
      .cur  (light[g]),
      .viol (viol[g])
    );
  end

  logic [NUM_DIR-1:0] nonred, m_ill, m_conf, m_trans, m_ysh, m_ylg, m_glg;
  logic               viol_any;
  logic [2:0]         vcode;
  logic [1:0]         vdir;

  // Gather per-kind masks and pick the lowest fault code, then lowest direction.
  always_comb begin
    for (int i = 0; i < NUM_DIR; i++) begin
      nonred[i]  = (light[i] != LIGHT_RED);
      m_ill[i]   = viol[i].illegal;
      m_trans[i] = viol[i].trans;
      m_ysh[i]   = viol[i].yshort;
      m_ylg[i]   = viol[i].ylong;
      m_glg[i]   = viol[i].glong;
    end
    m_conf   = ($countones(nonred) > 1) ? nonred : '0;
    viol_any = |{m_ill, m_conf, m_trans, m_ysh, m_ylg, m_glg};
    vcode    = FC_NONE;
    vdir     = DIR_N;
    if (|m_ill)        begin vcode = FC_ILLEGAL;  vdir = first_dir(m_ill);   end
    else if (|m_conf)  begin vcode = FC_CONFLICT; vdir = first_dir(m_conf);  end
    else if (|m_trans) begin vcode = FC_TRANS;    vdir = first_dir(m_trans); end
    else if (|m_ysh)   begin vcode = FC_YSHORT;   vdir = first_dir(m_ysh);   end
    else if (|m_ylg)   begin vcode = FC_YLONG;    vdir = first_dir(m_ylg);   end
    else if (|m_glg)   begin vcode = FC_GLONG;    vdir = first_dir(m_glg);   end
  end

  logic [1:0]                 state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [NUM_DIR-1:0][LW-1:0] lamp_q, lamp_d;
  logic                       fault_q, fault_d, safe_q, safe_d, clr_prev_q, clr_prev_d;
  logic [2:0]                 code_q, code_d;
  logic [1:0]                 dir_q, dir_d;
  logic [7:0]                 fcnt_q, fcnt_d;
  logic                       clr_rise;

  // A held fault_clr only counts once: require a low-to-high step.
  assign clr_rise = fault_clr && !clr_prev_q;

  // FSM next state, lamp drive and status registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lamp_d     = '0;
    fault_d    = 1'b0;
    safe_d     = 1'b0;
    code_d     = code_q;
    dir_d      = dir_q;
    fcnt_d     = fcnt_q;
    clr_prev_d = fault_clr;
    case (state_q)
      ST_ARM: begin
        if (cnt_q == 8'(ARM_CYCLES - 1)) begin
          state_d = ST_MONITOR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_MONITOR: begin
        if (viol_any) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          safe_d  = 1'b1;
          code_d  = vcode;
          dir_d   = vdir;
          fcnt_d  = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;
        end else begin
          lamp_d = light;
        end
      end
      ST_FAULT: begin
        safe_d = 1'b1;
        if (clr_rise) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          fault_d = 1'b1;
        end
      end
      default: begin
        if (cnt_q == 8'(HOLD_CYCLES - 1)) begin
          state_d = ST_ARM;
          cnt_d   = '0;
          code_d  = FC_NONE;
          dir_d   = DIR_N;
        end else begin
          safe_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q    <= ST_ARM;
      cnt_q      <= '0;
      lamp_q     <= '0;
      fault_q    <= 1'b0;
      safe_q     <= 1'b0;
      code_q     <= FC_NONE;
      dir_q      <= DIR_N;
      fcnt_q     <= '0;
      clr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lamp_q     <= lamp_d;
      fault_q    <= fault_d;
      safe_q     <= safe_d;
      code_q     <= code_d;
      dir_q      <= dir_d;
      fcnt_q     <= fcnt_d;
      clr_prev_q <= clr_prev_d;
    end
  end

  assign n_lamp     = lamp_q[DIR_N];
  assign s_lamp     = lamp_q[DIR_S];
  assign e_lamp     = lamp_q[DIR_E];
  assign w_lamp     = lamp_q[DIR_W];
  assign fault      = fault_q;
  assign safe_mode  = safe_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;
  assign fault_cnt  = fcnt_q;

endmodule
